// File: rtl/wb_mailbox_pkg.sv
// Shared definitions for the CPU-to-testbench mailbox: register offsets, status codes, state type.
package wb_mailbox_pkg;

    localparam logic [3:0] MBX_STATUS  = 4'h0;
    localparam logic [3:0] MBX_CONSOLE = 4'h4;
    localparam logic [3:0] MBX_CYCLES  = 4'h8;
    localparam logic [3:0] MBX_CTRL    = 4'hC;

    localparam logic [7:0] MBX_PASS = 8'h01;
    localparam logic [7:0] MBX_FAIL = 8'hFF;

    typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} mbx_state_t;

    // Word index of a byte offset; only address bits [3:2] are decoded.
    function automatic logic [1:0] mbx_word(input logic [3:0] off);
        return off[3:2];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [AddrW:0]   count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AddrW + 1)'(Depth));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AddrW'(1);
            if (do_pop)  rptr_q <= rptr_q + AddrW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AddrW + 1)'(1);
            else if (!do_push && do_pop) count_q <= count_q - (AddrW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_mailbox.sv
// Wishbone classic mailbox slave: pass/fail status, console byte FIFO and a cycle counter
// with hang timeout.
module wb_mailbox
    import wb_mailbox_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic            ack_q;
    logic [31:0]     dat_q, dat_d;
    logic [31:0]     cycles_q;
    mbx_state_t      state_q, state_d;
    logic            ovf_q, ovf_d;

    logic            access, wr_en, rd_en;
    logic [1:0]      word;
    logic            status_wr, push, pop, ovf_clr, timeout_hit;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic [7:0]      count8;
    logic            unused_bits;

    // Side effects commit only on the edge that raises ack.
    assign access = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en  = access & wb_we_i & wb_sel_i[0];
    assign rd_en  = access & ~wb_we_i;
    assign word   = wb_adr_i[3:2];

    assign status_wr   = wr_en && (word == mbx_word(MBX_STATUS));
    assign push        = wr_en && (word == mbx_word(MBX_CONSOLE));
    assign ovf_clr     = wr_en && (word == mbx_word(MBX_CTRL)) && wb_dat_i[0];
    assign pop         = con_valid_o & con_ready_i;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycles_q == 32'(TIMEOUT_CYCLES));
    assign count8      = 8'(fifo_count);

    sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (wb_dat_i[7:0]),
        .pop_i   (pop),
        .rdata_o (con_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == RUN) begin
            if (status_wr && wb_dat_i[7:0] == MBX_PASS)      state_d = PASS;
            else if (status_wr && wb_dat_i[7:0] == MBX_FAIL) state_d = FAIL;
            else if (timeout_hit)                             state_d = TIMEOUT;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_comb begin
        dat_d = '0;
        if (rd_en) begin
            case (word)
                mbx_word(MBX_STATUS):  dat_d = {28'b0, timeout_o, fail_o, pass_o, done_o};
                mbx_word(MBX_CONSOLE): dat_d = {16'b0, count8, 5'b0, ovf_q, fifo_full, fifo_empty};
                mbx_word(MBX_CYCLES):  dat_d = cycles_q;
                default:               dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            cycles_q <= '0;
            state_q  <= RUN;
            ovf_q    <= 1'b0;
        end else begin
            ack_q    <= wb_cyc_i & wb_stb_i & ~ack_q;
            dat_q    <= dat_d;
            cycles_q <= cycles_q + 32'd1;
            state_q  <= state_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign done_o      = (state_q != RUN);
    assign pass_o      = (state_q == PASS);
    assign fail_o      = (state_q == FAIL);
    assign timeout_o   = (state_q == TIMEOUT);
    assign con_valid_o = ~fifo_empty;

    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

endmodule

// File: tb/tb_wb_mailbox.sv
// Scoreboarded bench for wb_mailbox: bus tasks queue expected read data, a monitor checks on ack.
module tb_wb_mailbox;
    import wb_mailbox_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [3:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        done_o, pass_o, fail_o, timeout_o, con_valid_o;
    logic [7:0]  con_data_o;
    logic        con_ready_i = 1'b0;

    always #5 clk = ~clk;

    wb_mailbox #(
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_i    (wb_sel_i),
        .wb_ack_o    (wb_ack_o),
        .wb_dat_o    (wb_dat_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .timeout_o   (timeout_o),
        .con_valid_o (con_valid_o),
        .con_data_o  (con_data_o),
        .con_ready_i (con_ready_i)
    );

    typedef struct {
        logic        is_rd;
        logic [31:0] dat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry; reads are compared.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wb_ack_o) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack with data 0x%08h, expected no ack", wb_dat_o);
            end else begin
                e = sb.pop_front();
                if (e.is_rd) check(e.name, wb_dat_o, e.dat);
            end
        end
    end

    task automatic bus(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_rd, input string name);
        exp_t e;
        int   lat;
        bit   got;
        e.is_rd = !we;
        e.dat   = exp_rd;
        e.name  = name;
        sb.push_back(e);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (wb_ack_o) got = 1'b1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        check({name, "_ack_lat"}, 32'(lat), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input string name);
        bus(1'b1, adr, dat, 4'hF, 32'h0, name);
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'h0, 4'hF, exp, name);
    endtask

    task automatic reset_dut;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected $finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] b2b_pat;

        // Reset state
        reset_dut();
        check("rst_outs", {27'b0, done_o, pass_o, fail_o, timeout_o, con_valid_o}, 32'h0);
        check("rst_ack", {31'b0, wb_ack_o}, 32'h0);
        rd(MBX_CYCLES, 32'd1, "rst_cycles");
        rd(MBX_STATUS, 32'h0, "rst_status");
        rd(MBX_CONSOLE, 32'h0000_0001, "rst_console");
        rd(MBX_CTRL, 32'h0, "ctrl_read");

        // PASS
        reset_dut();
        wr(MBX_STATUS, 32'h0000_0001, "wr_pass");
        check("pass_done", {30'b0, pass_o, done_o}, 32'h3);
        rd(MBX_STATUS, 32'h3, "pass_status");

        // FAIL is terminal
        reset_dut();
        wr(MBX_STATUS, 32'h0000_00FF, "wr_fail");
        wr(MBX_STATUS, 32'h0000_0001, "wr_after_fail");
        check("fail_hold", {29'b0, fail_o, pass_o, done_o}, 32'h5);
        rd(MBX_STATUS, 32'h5, "fail_status");

        // Other status codes and byte-0-deselected writes are ignored
        reset_dut();
        wr(MBX_STATUS, 32'h0000_0042, "wr_other");
        bus(1'b1, MBX_STATUS, 32'h0000_0001, 4'hE, 32'h0, "wr_nosel");
        rd(MBX_STATUS, 32'h0, "ignored_status");

        // Console bytes
        reset_dut();
        wr(MBX_CONSOLE, 32'h48, "push_H");
        wr(MBX_CONSOLE, 32'h69, "push_i");
        bus(1'b1, MBX_CONSOLE, 32'h58, 4'hE, 32'h0, "push_nosel");
        check("con_head_H", {23'b0, con_valid_o, con_data_o}, 32'h148);
        rd(MBX_CONSOLE, 32'h0000_0200, "con_count2");
        @(negedge clk);
        con_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("con_head_i", {23'b0, con_valid_o, con_data_o}, 32'h169);
        @(posedge clk);
        #1;
        check("con_drained", {31'b0, con_valid_o}, 32'h0);
        con_ready_i = 1'b0;

        // Overflow and clear
        reset_dut();
        for (int i = 0; i < 17; i++) wr(MBX_CONSOLE, 32'h10 + 32'(i), "push_fill");
        check("full_head", {24'b0, con_data_o}, 32'h10);
        rd(MBX_CONSOLE, 32'h0000_1006, "con_overflow");
        wr(MBX_CTRL, 32'h1, "ovf_clear");
        rd(MBX_CONSOLE, 32'h0000_1002, "con_cleared");

        // Timeout: counter reaches 50 before edge 51 after release
        reset_dut();
        repeat (50) @(posedge clk);
        #1;
        check("timeout_early", {31'b0, timeout_o}, 32'h0);
        @(posedge clk);
        #1;
        check("timeout_hit", {30'b0, timeout_o, done_o}, 32'h3);
        rd(MBX_STATUS, 32'h9, "timeout_status");

        // STATUS write on the timeout edge wins
        reset_dut();
        repeat (50) @(posedge clk);
        #1;
        wr(MBX_STATUS, 32'h1, "wr_on_timeout");
        check("race_pass", {29'b0, timeout_o, pass_o, done_o}, 32'h3);

        // Cycle dropped before ack has no effect
        reset_dut();
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = MBX_STATUS; wb_dat_i = 32'h1; wb_sel_i = 4'hF;
        #2;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk);
        #1;
        check("abort_noack", {30'b0, wb_ack_o, pass_o}, 32'h0);

        // Held strobe: acks on alternate cycles
        reset_dut();
        begin
            exp_t e;
            e.is_rd = 1'b1;
            e.dat   = 32'h0;
            e.name  = "b2b_status";
            sb.push_back(e);
            sb.push_back(e);
        end
        b2b_pat = 4'b0101;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = MBX_STATUS;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("b2b_ack", {31'b0, wb_ack_o}, {31'b0, b2b_pat[i]});
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset with a pending ack in PASS
        reset_dut();
        wr(MBX_STATUS, 32'h1, "wr_pass2");
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = MBX_STATUS;
        @(posedge clk);
        #1;
        check("pend_ack_pass", {30'b0, wb_ack_o, pass_o}, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {26'b0, wb_ack_o, done_o, pass_o, fail_o, timeout_o, con_valid_o},
              32'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(MBX_CYCLES, 32'd1, "cycles_after_rst");

        repeat (2) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_mailbox.md
# wb_mailbox

Synthesizable Wishbone classic slave that is the responder end of the CPU-to-testbench mailbox: firmware writes pass/fail codes and console bytes to it over the SoC data bus. It decodes the status code into a terminal state, buffers console bytes in a FIFO for a host-side drain port, and runs a cycle counter with a hang timeout. It sits on the SoC Wishbone interconnect beside the SRAM. Benches and FPGA LED logic watch its status outputs instead of snooping bus signals.

## Interface
- `FIFO_DEPTH`, 16: console FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 200_000: cycles in RUN before forcing TIMEOUT; 0 disables the timeout.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe; slave already selected by the interconnect.
- `wb_we_i` in 1: 1 = write.
- `wb_adr_i` in 4: byte offset; only bits [3:2] decoded.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte lanes; byte 0 must be selected for any write effect.
- `wb_ack_o` out 1: one-cycle acknowledge.
- `wb_dat_o` out 32: read data, valid while `wb_ack_o` = 1, else 0.
- `done_o` out 1: state is not RUN.
- `pass_o` out 1: state is PASS.
- `fail_o` out 1: state is FAIL.
- `timeout_o` out 1: state is TIMEOUT.
- `con_valid_o` out 1: FIFO not empty.
- `con_data_o` out 8: FIFO head (first-word fall-through).
- `con_ready_i` in 1: pop the head when `con_valid_o` is 1.

## Operation
- Register map:
  - 0x0 STATUS, write: byte 0 = 0x01 → PASS; byte 0 = 0xFF → FAIL; other values ignored.
  - 0x0 STATUS, read: {28'b0, timeout, fail, pass, done}.
  - 0x4 CONSOLE, write: push byte 0.
  - 0x4 CONSOLE, read: {16'b0, count[7:0], 5'b0, overflow, full, empty}.
  - 0x8 CYCLES, read: 32-bit free-running cycle counter; wraps at 2^32.
  - 0xC CTRL, write: bit 0 = 1 clears the overflow flag; reads return 0.
  - Writes to read-only fields are ignored.
- State machine: RUN → PASS / FAIL / TIMEOUT.
  - RUN leaves on a STATUS write of 0x01 or 0xFF, or when `TIMEOUT_CYCLES` ≠ 0 and the cycle counter equals `TIMEOUT_CYCLES`.
  - Terminal states hold until reset. Later STATUS writes are acknowledged and ignored.
  - If a STATUS write and the timeout happen on the same edge, the write wins.
- Cycle counter: increments every cycle from 0 after reset, including in terminal states.
- Console FIFO:
  - A push when full is dropped and sets sticky overflow.
  - A push when full with a pop on the same edge is accepted; count is unchanged.
  - A pop when empty is ignored.
  - Overflow clear and a new overflow on the same edge: set wins.
  - Pointers wrap modulo `FIFO_DEPTH`; count is a separate `$clog2(FIFO_DEPTH)+1`-bit field.

## Timing
- Acknowledge: `wb_ack_o` registers `wb_cyc_i & wb_stb_i & ~wb_ack_o`. Every access therefore takes 2 cycles and ack is high for exactly one cycle.
- Back-to-back strobes get ack on alternate cycles.
- Write side effects (state change, push, clear) commit on the same edge that raises `wb_ack_o`. They are visible on outputs and in CYCLES/STATUS reads from the next cycle.
- Read data is registered on that same edge and reflects pre-edge state.
- `done_o`/`pass_o`/`fail_o`/`timeout_o` are registered and assert the cycle after the committing edge.
- Pop commits on the edge where `con_valid_o & con_ready_i`; the new head appears the next cycle.
- If `wb_cyc_i` drops mid-access before ack, no side effect occurs.
- Reset values: all outputs 0, state RUN, counter 0, FIFO empty, overflow 0.
- Reset asserted mid-access drops ack immediately (asynchronous).

## Structure
- `wb_mailbox_pkg` holds:
  - register offsets: `MBX_STATUS`, `MBX_CONSOLE`, `MBX_CYCLES`, `MBX_CTRL`;
  - status codes: `MBX_PASS` = 8'h01, `MBX_FAIL` = 8'hFF;
  - state enum `mbx_state_t` {RUN, PASS, FAIL, TIMEOUT}.
- Sub-module `sync_fifo`:
  - parameterized width/depth, first-word fall-through;
  - push/pop/full/empty/count;
  - same clock and reset as the parent.

## Test plan
- Write 0x0000_0001 to 0x0 with sel=4'hF → ack 1 cycle after stb; next cycle `pass_o` = 1 and `done_o` = 1; STATUS read = 0x3.
- Write 0xFF to 0x0, then 0x01 → `fail_o` = 1 and stays; STATUS reads 0x5 after both writes.
- Push 'H','i' with `con_ready_i` = 0 → `con_valid_o` = 1, `con_data_o` = 0x48; CONSOLE read = 0x0000_0200. Raise ready for 2 cycles → 0x69 then empty.
- 17 pushes into depth 16 with ready = 0 → 17th dropped; CONSOLE read = 0x0000_1006; CTRL write 1 → 0x0000_1002.
- `TIMEOUT_CYCLES` = 50, no writes → `timeout_o` = 1 at cycle 51. Same run with a STATUS 0x01 write committing on the timeout edge → PASS.
- Assert `rst_n` = 0 during a pending strobe and in PASS → ack and all outputs 0 immediately; CYCLES read after release counts from 0.
